// File: rtl/cordic_vec_arbiter_if.sv
// rtl/cordic_vec_arbiter_if.sv - requester and CORDIC signal bundle for cordic_vec_arbiter
//
// Groups every non-clock signal of the arbiter.
//   slave  : the arbiter side (drives gnt/rsp_* /busy/cordic_in*/cordic_valid).
//   master : the environment side (requesters plus the CORDIC unit).
// Signals:
//   req[N_REQ]            request level per requester
//   req_x/req_y           flattened operands, requester i at [i*WORDLEN +: WORDLEN]
//   gnt[N_REQ]            one-hot grant pulse
//   rsp_valid[N_REQ]      one-hot response pulse
//   rsp_mag/rsp_theta     returned results
//   rsp_err               response produced by the timeout path
//   busy                  arbiter not idle
//   cordic_in1/in2/valid  issue side of the CORDIC
//   cordic_mag/theta/done completion side of the CORDIC
interface cordic_vec_arbiter_if #(
  parameter int WORDLEN = 16,
  parameter int N_REQ   = 4
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WORDLEN-1:0] req_x;
  logic [N_REQ*WORDLEN-1:0] req_y;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rsp_valid;
  logic [WORDLEN-1:0]       rsp_mag;
  logic [WORDLEN-1:0]       rsp_theta;
  logic                     rsp_err;
  logic                     busy;
  logic [WORDLEN-1:0]       cordic_in1;
  logic [WORDLEN-1:0]       cordic_in2;
  logic                     cordic_valid;
  logic [WORDLEN-1:0]       cordic_mag;
  logic [WORDLEN-1:0]       cordic_theta;
  logic                     cordic_done;

  modport slave (
    input  req, req_x, req_y, cordic_mag, cordic_theta, cordic_done,
    output gnt, rsp_valid, rsp_mag, rsp_theta, rsp_err, busy,
           cordic_in1, cordic_in2, cordic_valid
  );

  modport master (
    output req, req_x, req_y, cordic_mag, cordic_theta, cordic_done,
    input  gnt, rsp_valid, rsp_mag, rsp_theta, rsp_err, busy,
           cordic_in1, cordic_in2, cordic_valid
  );
endinterface

// File: rtl/cordic_vec_arbiter.sv
// rtl/cordic_vec_arbiter.sv - round-robin sharing of one vectoring CORDIC between N_REQ requesters
//
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  cordic_vec_arbiter_if.slave (requests/operands in, grants/responses out,
//        CORDIC issue outputs, CORDIC completion inputs)
// Flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs come straight from flops.
// Optional: define CVA_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles; a
// timed-out transaction responds with mag = theta = 0 and rsp_err = 1. Without it
// WAIT has no bound and rsp_err is constant 0.
module cordic_vec_arbiter #(
  parameter int WORDLEN = 16,
  parameter int N_REQ   = 4,
  parameter int IDXLEN  = 2,
  parameter int TIMEOUT = 32,
  parameter int TOLEN   = 6
) (
  input  logic               CLK,
  input  logic               RST,
  cordic_vec_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDXLEN-1:0]  sel_q, sel_d;
  logic [IDXLEN-1:0]  last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WORDLEN-1:0] rsp_mag_q, rsp_mag_d;
  logic [WORDLEN-1:0] rsp_theta_q, rsp_theta_d;
  logic               busy_q, busy_d;
  logic [WORDLEN-1:0] cordic_in1_q, cordic_in1_d;
  logic [WORDLEN-1:0] cordic_in2_q, cordic_in2_d;
  logic               cordic_valid_q, cordic_valid_d;

`ifdef CVA_TIMEOUT_EN
  logic               rsp_err_q, rsp_err_d;
  logic [TOLEN-1:0]   to_cnt_q, to_cnt_d;
`else
  logic               unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TOLEN};
`endif

  // Round-robin pick: first set req bit strictly after last_q, wrapping.
  logic               found;
  logic [IDXLEN-1:0]  cand;
  logic [IDXLEN-1:0]  pick;
  logic [WORDLEN-1:0] x_pick, y_pick;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    pick  = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDXLEN'((int'(last_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    x_pick = '0;
    y_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IDXLEN'(i)) begin
        x_pick = bus.req_x[i*WORDLEN +: WORDLEN];
        y_pick = bus.req_y[i*WORDLEN +: WORDLEN];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    last_d         = last_q;
    gnt_d          = '0;
    rsp_valid_d    = '0;
    rsp_mag_d      = rsp_mag_q;
    rsp_theta_d    = rsp_theta_q;
    cordic_in1_d   = cordic_in1_q;
    cordic_in2_d   = cordic_in2_q;
    cordic_valid_d = 1'b0;
`ifdef CVA_TIMEOUT_EN
    rsp_err_d      = rsp_err_q;
    to_cnt_d       = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d        = pick;
          cordic_in1_d = x_pick;
          cordic_in2_d = y_pick;
          gnt_d        = N_REQ'(1) << pick;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // cordic_valid_q rises on the first WAIT cycle, one cycle after gnt.
        cordic_valid_d = 1'b1;
        state_d        = S_WAIT;
`ifdef CVA_TIMEOUT_EN
        to_cnt_d       = '0;
`endif
      end
      S_WAIT: begin
        if (bus.cordic_done) begin
          rsp_mag_d   = bus.cordic_mag;
          rsp_theta_d = bus.cordic_theta;
          rsp_valid_d = N_REQ'(1) << sel_q;
          state_d     = S_RESP;
`ifdef CVA_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef CVA_TIMEOUT_EN
        // to_cnt_q counts completed WAIT cycles; this is the TIMEOUT-th one.
        // A done in this same cycle was handled above and takes priority.
        else if (to_cnt_q == TOLEN'(TIMEOUT - 1)) begin
          rsp_mag_d   = '0;
          rsp_theta_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = N_REQ'(1) << sel_q;
          state_d     = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TOLEN'(1);
        end
`endif
      end
      default: begin
        // RESP: the gap back through IDLE keeps the CORDIC idle before reissue.
        last_d  = sel_q;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      last_q         <= IDXLEN'(N_REQ - 1);
      gnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_mag_q      <= '0;
      rsp_theta_q    <= '0;
      busy_q         <= 1'b0;
      cordic_in1_q   <= '0;
      cordic_in2_q   <= '0;
      cordic_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      last_q         <= last_d;
      gnt_q          <= gnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_mag_q      <= rsp_mag_d;
      rsp_theta_q    <= rsp_theta_d;
      busy_q         <= busy_d;
      cordic_in1_q   <= cordic_in1_d;
      cordic_in2_q   <= cordic_in2_d;
      cordic_valid_q <= cordic_valid_d;
    end
  end

`ifdef CVA_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      rsp_err_q <= rsp_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.gnt          = gnt_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_mag      = rsp_mag_q;
  assign bus.rsp_theta    = rsp_theta_q;
  assign bus.busy         = busy_q;
  assign bus.cordic_in1   = cordic_in1_q;
  assign bus.cordic_in2   = cordic_in2_q;
  assign bus.cordic_valid = cordic_valid_q;

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// tb/tb_cordic_vec_arbiter.sv - self-checking bench for cordic_vec_arbiter
module tb_cordic_vec_arbiter;
  localparam int WL  = 16;
  localparam int NR  = 4;
  localparam int IL  = 2;
  localparam int TO  = 32;
  localparam int TOL = 6;
`ifdef CVA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cordic_vec_arbiter_if #(.WORDLEN(WL), .N_REQ(NR)) bus ();
  cordic_vec_arbiter #(.WORDLEN(WL), .N_REQ(NR), .IDXLEN(IL), .TIMEOUT(TO), .TOLEN(TOL))
    dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Transaction-level reference: grant cycle, done cycle, chosen requester.
  bit          m_act;
  int          m_g, m_d, m_sel, m_last;
  logic [NR-1:0] e_gnt, e_rv;
  logic [WL-1:0] e_in1, e_in2, e_mag, e_th;
  logic          e_err, e_busy, e_cv;

  // Environment state.
  bit          stub_en;
  bit          spur_en;
  int          stub_cnt;
  int          stub_lat;
  logic [WL-1:0] stub_x, stub_y;
  logic [NR-1:0] auto_mask;
  int          raise_pct;
  logic [NR-1:0] hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_g = -1; m_d = -1; m_sel = 0; m_last = NR - 1;
    e_gnt = '0; e_rv = '0; e_in1 = '0; e_in2 = '0; e_mag = '0; e_th = '0;
    e_err = 1'b0; e_busy = 1'b0; e_cv = 1'b0;
  endtask

  // Predicts outputs of cycle cyc+1 from the inputs present during cycle cyc.
  task automatic model_step();
    e_gnt = '0; e_rv = '0; e_cv = 1'b0;
    if (!m_act) begin
      e_busy = 1'b0;
      if (bus.req != '0) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (m_last + k) % NR;
          if (bus.req[j]) begin m_sel = j; break; end
        end
        e_gnt[m_sel] = 1'b1;
        e_in1 = bus.req_x[m_sel*WL +: WL];
        e_in2 = bus.req_y[m_sel*WL +: WL];
        m_act = 1'b1; m_g = cyc + 1; m_d = -1; e_busy = 1'b1;
      end
    end else if (cyc == m_g) begin
      e_cv = 1'b1; e_busy = 1'b1;
    end else if (m_d < 0) begin
      e_busy = 1'b1;
      if (bus.cordic_done) begin
        e_mag = bus.cordic_mag; e_th = bus.cordic_theta; e_err = 1'b0;
        e_rv[m_sel] = 1'b1; m_d = cyc;
      end else if (TO_EN && (cyc - m_g == TO)) begin
        e_mag = '0; e_th = '0; e_err = 1'b1;
        e_rv[m_sel] = 1'b1; m_d = cyc;
      end
    end else begin
      m_last = m_sel; m_act = 1'b0; e_busy = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("gnt",          32'(bus.gnt),          32'(e_gnt));
    chk("rsp_valid",    32'(bus.rsp_valid),    32'(e_rv));
    chk("rsp_mag",      32'(bus.rsp_mag),      32'(e_mag));
    chk("rsp_theta",    32'(bus.rsp_theta),    32'(e_th));
    chk("rsp_err",      32'(bus.rsp_err),      32'(e_err));
    chk("busy",         32'(bus.busy),         32'(e_busy));
    chk("cordic_in1",   32'(bus.cordic_in1),   32'(e_in1));
    chk("cordic_in2",   32'(bus.cordic_in2),   32'(e_in2));
    chk("cordic_valid", 32'(bus.cordic_valid), 32'(e_cv));
    chk("gnt_onehot0",  32'($countones(bus.gnt) <= 1), 32'd1);
  endtask

  // CORDIC stub: answers L cycles after the valid pulse; garbage otherwise.
  task automatic stub_drive();
    bus.cordic_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        bus.cordic_done = 1'b1;
        if (stub_x == 16'h0C00 && stub_y == 16'h1000) begin
          bus.cordic_mag = 16'h1400; bus.cordic_theta = 16'h03B6;
        end else begin
          bus.cordic_mag = stub_x ^ stub_y; bus.cordic_theta = stub_x + stub_y;
        end
      end
    end
    if (!bus.cordic_done) begin
      bus.cordic_mag = WL'($urandom); bus.cordic_theta = WL'($urandom);
      if (spur_en && !bus.busy && $urandom_range(0, 9) == 0) bus.cordic_done = 1'b1;
    end
    if (stub_en && bus.cordic_valid) begin
      stub_cnt = stub_lat; stub_x = bus.cordic_in1; stub_y = bus.cordic_in2;
    end
  endtask

  task automatic req_drive();
    for (int i = 0; i < NR; i++) begin
      if (bus.gnt[i]) begin
        bus.req[i] = 1'b0; hold[i] = 1'b1;
      end else if (hold[i]) begin
        hold[i] = 1'b0;
      end else if (auto_mask[i] && !bus.req[i] && $urandom_range(0, 99) < raise_pct) begin
        bus.req[i] = 1'b1;
        bus.req_x[i*WL +: WL] = WL'($urandom);
        bus.req_y[i*WL +: WL] = WL'($urandom);
      end
    end
  endtask

  task automatic tick();
    if (RST) model_reset(); else model_step();
    @(posedge CLK); #1;
    cyc++;
    compare_all();
    stub_drive();
    req_drive();
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
  endtask

  task automatic wait_gnt(input string nm, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus.gnt != '0) begin at = cyc; break; end
    end
    chk({nm, "_gnt_seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_rsp(input string nm, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus.rsp_valid != '0) begin at = cyc; break; end
    end
    chk({nm, "_rsp_seen"}, 32'(at >= 0), 32'd1);
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int tg, tr, nrsp, nr_rand;
    int order[5];
    RST = 1'b1;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0;
    bus.cordic_mag = '0; bus.cordic_theta = '0; bus.cordic_done = 1'b0;
    stub_en = 1'b0; spur_en = 1'b0; stub_cnt = 0; stub_lat = 14;
    stub_x = '0; stub_y = '0; auto_mask = '0; raise_pct = 0; hold = '0;
    model_reset();
    tick(); tick(); tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_in1",  32'(bus.cordic_in1), 32'd0);
    RST = 1'b0;

    // Directed 3,4 -> 5, atan2(4,3).
    stub_en = 1'b1; stub_lat = 14;
    bus.req_x[0 +: WL] = 16'h0C00; bus.req_y[0 +: WL] = 16'h1000; bus.req = 4'b0001;
    wait_gnt("p1", tg);
    chk("p1_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("p1_valid_after_gnt", 32'(bus.cordic_valid), 32'd1);
    wait_rsp("p1", tr);
    chk("p1_latency", 32'(tr - tg), 32'd16);
    chk("p1_rv",    32'(bus.rsp_valid), 32'h1);
    chk("p1_mag",   32'(bus.rsp_mag),   32'h1400);
    chk("p1_theta", 32'(bus.rsp_theta), 32'h03B6);
    chk("p1_err",   32'(bus.rsp_err),   32'd0);
    tick(); tick();

    // All four requesting continuously from a fresh reset.
    do_reset();
    auto_mask = 4'b1111; raise_pct = 100; bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("p2", tg);
      order[k] = idx_of(bus.gnt);
    end
    auto_mask = '0; bus.req = '0;
    chk("p2_order0", 32'(order[0]), 32'd0);
    chk("p2_order1", 32'(order[1]), 32'd1);
    chk("p2_order2", 32'(order[2]), 32'd2);
    chk("p2_order3", 32'(order[3]), 32'd3);
    chk("p2_order4", 32'(order[4]), 32'd0);
    wait_rsp("p2", tr);
    tick(); tick();

    // Wrap-around: last = 2, then 0 and 1 request together.
    bus.req = 4'b0100;
    wait_gnt("p3a", tg);
    wait_rsp("p3a", tr);
    tick();
    bus.req = 4'b0011;
    wait_gnt("p3", tg);
    chk("p3_wrap_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    wait_rsp("p3", tr);
    tick(); tick();

    // Spurious done in IDLE and ISSUE.
    stub_en = 1'b0;
    bus.cordic_done = 1'b1;
    tick();
    chk("p4_idle_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b1000;
    wait_gnt("p4", tg);
    bus.cordic_done = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("p4_still_busy", 32'(bus.busy), 32'd1);
    bus.cordic_done = 1'b1; bus.cordic_mag = 16'h1234; bus.cordic_theta = 16'h0567;
    nrsp = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.rsp_valid != '0) begin
        nrsp++;
        chk("p4_mag", 32'(bus.rsp_mag), 32'h1234);
        chk("p4_rv",  32'(bus.rsp_valid), 32'h8);
      end
    end
    chk("p4_one_rsp", 32'(nrsp), 32'd1);

    // Asynchronous reset five cycles into WAIT.
    bus.req = 4'b0010;
    wait_gnt("p5", tg);
    for (int k = 0; k < 5; k++) tick();
    #2 RST = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("p5_async_busy", 32'(bus.busy), 32'd0);
    chk("p5_async_in2",  32'(bus.cordic_in2), 32'd0);
    tick(); tick();
    RST = 1'b0;
    bus.cordic_done = 1'b1;
    tick();
    chk("p5_late_done", 32'(bus.busy), 32'd0);
    stub_en = 1'b1; stub_lat = 14;
    bus.req = 4'b0100;
    wait_gnt("p5b", tg);
    chk("p5_gnt", 32'(bus.gnt), 32'h4);
    wait_rsp("p5b", tr);
    chk("p5_rv", 32'(bus.rsp_valid), 32'h4);
    tick();

    // CORDIC that never answers.
    stub_en = 1'b0;
    bus.req = 4'b0001;
    wait_gnt("p6", tg);
    tr = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.rsp_valid != '0 && tr < 0) tr = cyc;
    end
`ifdef CVA_TIMEOUT_EN
    chk("p6_to_latency", 32'(tr - tg), 32'd33);
    chk("p6_err",   32'(bus.rsp_err), 32'd1);
    chk("p6_mag",   32'(bus.rsp_mag), 32'd0);
    chk("p6_theta", 32'(bus.rsp_theta), 32'd0);
`else
    chk("p6_no_rsp", 32'(tr), 32'hFFFF_FFFF);
    chk("p6_busy",   32'(bus.busy), 32'd1);
`endif
    do_reset();

    // Randomized traffic with random CORDIC latency and spurious done in IDLE.
    stub_en = 1'b1; spur_en = 1'b1;
    auto_mask = 4'b1111; raise_pct = 30;
    nr_rand = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!bus.busy) stub_lat = $urandom_range(1, 20);
      tick();
      if (bus.rsp_valid != '0) nr_rand++;
    end
    chk("rand_activity", 32'(nr_rand > 50), 32'd1);
    auto_mask = '0; spur_en = 1'b0; bus.req = '0;
    for (int k = 0; k < 40; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
